// File: rtl/axis_fir_param.sv
// Parametrised direct-form FIR filter with AXI4-Stream input and output.
// Three pipeline stages: delay line, per-tap products, adder tree into a full-precision sum.
// Coefficients are runtime-writable and reset to a unit impulse so the block
// passes samples through unchanged until it is programmed.
module axis_fir_param #(
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned COEF_W        = 16,
  parameter int unsigned NTAPS         = 15,
  parameter int unsigned CLEAR_ON_LAST = 0,
  localparam int unsigned OUT_W        = DATA_W + COEF_W + $clog2(NTAPS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] s_axis_tdata,
  input  logic                     s_axis_tvalid,
  input  logic                     s_axis_tlast,
  output logic                     s_axis_tready,
  output logic signed [OUT_W-1:0]  m_axis_tdata,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready,
  input  logic                     coef_we,
  input  logic [5:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata
);

  localparam int unsigned ProdW = DATA_W + COEF_W;

  logic ce;
  logic accept;

  logic signed [DATA_W-1:0] dl_q   [NTAPS];
  logic signed [DATA_W-1:0] dl_d   [NTAPS];
  logic signed [COEF_W-1:0] coef_q [NTAPS];
  logic signed [COEF_W-1:0] coef_d [NTAPS];
  logic signed [ProdW-1:0]  p_q    [NTAPS];
  logic signed [ProdW-1:0]  p_d    [NTAPS];
  logic signed [OUT_W-1:0]  sum_d;
  logic signed [OUT_W-1:0]  y_q;

  logic clr_pend_q, clr_pend_d;
  logic v1_q, t1_q;
  logic v2_q, t2_q;
  logic v3_q, t3_q;

  // The whole pipeline stalls only when the output slot is full and not taken.
  assign ce            = !(v3_q && !m_axis_tready);
  assign s_axis_tready = reset && ce;
  assign accept        = s_axis_tvalid && s_axis_tready;

  assign m_axis_tdata  = y_q;
  assign m_axis_tvalid = v3_q;
  assign m_axis_tlast  = t3_q;

  // Delay line shifts only on accepted samples; a pending clear wipes the old history.
  always_comb begin
    dl_d       = dl_q;
    clr_pend_d = clr_pend_q;
    if (accept) begin
      dl_d[0] = s_axis_tdata;
      for (int unsigned i = 1; i < NTAPS; i++) begin
        dl_d[i] = ((CLEAR_ON_LAST != 0) && clr_pend_q) ? '0 : dl_q[i-1];
      end
      clr_pend_d = (CLEAR_ON_LAST != 0) && s_axis_tlast;
    end
  end

  // Coefficient writes land regardless of pipeline stalls; out-of-range taps are dropped.
  always_comb begin
    coef_d = coef_q;
    for (int unsigned i = 0; i < NTAPS; i++) begin
      if (coef_we && (coef_addr == 6'(i))) begin
        coef_d[i] = coef_wdata;
      end
    end
  end

  // Per-tap signed products at full width.
  always_comb begin
    for (int unsigned i = 0; i < NTAPS; i++) begin
      p_d[i] = ProdW'(dl_q[i]) * ProdW'(coef_q[i]);
    end
  end

  // Exact sum of sign-extended products; OUT_W has enough headroom for NTAPS terms.
  always_comb begin
    sum_d = '0;
    for (int unsigned i = 0; i < NTAPS; i++) begin
      sum_d = sum_d + OUT_W'(p_q[i]);
    end
  end

  // Delay line, clear-pending flag and coefficient storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NTAPS; i++) begin
        dl_q[i]   <= '0;
        coef_q[i] <= (i == 0) ? COEF_W'(1) : '0;
      end
      clr_pend_q <= 1'b0;
    end else begin
      dl_q       <= dl_d;
      coef_q     <= coef_d;
      clr_pend_q <= clr_pend_d;
    end
  end

  // Valid/last sideband and datapath stages, all advancing together on ce.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NTAPS; i++) begin
        p_q[i] <= '0;
      end
      v1_q <= 1'b0;
      t1_q <= 1'b0;
      v2_q <= 1'b0;
      t2_q <= 1'b0;
      v3_q <= 1'b0;
      t3_q <= 1'b0;
      y_q  <= '0;
    end else if (ce) begin
      v1_q <= accept;
      t1_q <= accept && s_axis_tlast;
      p_q  <= p_d;
      v2_q <= v1_q;
      t2_q <= t1_q;
      y_q  <= sum_d;
      v3_q <= v2_q;
      t3_q <= t2_q;
    end
  end

endmodule

// File: tb/tb_axis_fir_param.sv
// Bench for axis_fir_param: two instances (history clear off/on) share all stimulus and
// are checked against a convolution model that predicts one output per accepted sample.
module tb_axis_fir_param;

  localparam int NT = 15;
  localparam int OW = 36;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic signed [15:0] s_tdata;
  logic               s_tvalid;
  logic               s_tlast;
  logic               m_tready;
  logic               coef_we;
  logic [5:0]         coef_addr;
  logic signed [15:0] coef_wdata;

  logic [OW-1:0] m_tdata  [2];
  logic          m_tvalid [2];
  logic          m_tlast  [2];
  logic          s_tready [2];

  axis_fir_param #(.CLEAR_ON_LAST(0)) u_dut0 (
    .clk           (clk),
    .reset         (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready[0]),
    .m_axis_tdata  (m_tdata[0]),
    .m_axis_tvalid (m_tvalid[0]),
    .m_axis_tlast  (m_tlast[0]),
    .m_axis_tready (m_tready),
    .coef_we       (coef_we),
    .coef_addr     (coef_addr),
    .coef_wdata    (coef_wdata)
  );

  axis_fir_param #(.CLEAR_ON_LAST(1)) u_dut1 (
    .clk           (clk),
    .reset         (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready[1]),
    .m_axis_tdata  (m_tdata[1]),
    .m_axis_tvalid (m_tvalid[1]),
    .m_axis_tlast  (m_tlast[1]),
    .m_axis_tready (m_tready),
    .coef_we       (coef_we),
    .coef_addr     (coef_addr),
    .coef_wdata    (coef_wdata)
  );

  typedef struct {
    logic [OW-1:0] d;
    logic          l;
    int            c;
  } exp_t;

  int  checks = 0;
  int  errors = 0;
  int  cnt    = 0;
  int  vcount = 0;
  bit  lat_chk  = 1'b0;
  bit  rand_rdy = 1'b0;
  bit  acc_seen = 1'b0;

  exp_t   q0[$];
  exp_t   q1[$];
  longint hist [2][NT];
  longint cm   [NT];
  bit     pend [2];
  bit            held [2];
  logic [OW-1:0] hd   [2];
  logic          hl   [2];
  logic [OW-1:0] last_obs;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Power-on state of the model: unit-impulse coefficients, empty history, nothing in flight.
  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin
      cm[i]      = (i == 0) ? 64'sd1 : 64'sd0;
      hist[0][i] = 0;
      hist[1][i] = 0;
    end
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    held[0] = 1'b0;
    held[1] = 1'b0;
    q0.delete();
    q1.delete();
  endtask

  // y = sum_k coef[k] * x[n-k]; instance 1 forgets history after a tlast sample.
  task automatic model_accept(input int d);
    longint y;
    exp_t   e;
    y = 0;
    if (pend[d]) begin
      for (int i = 0; i < NT; i++) hist[d][i] = 0;
    end
    for (int i = NT - 1; i > 0; i--) hist[d][i] = hist[d][i-1];
    hist[d][0] = longint'(s_tdata);
    pend[d]    = (d == 1) && s_tlast;
    for (int i = 0; i < NT; i++) y += cm[i] * hist[d][i];
    e.d = y[OW-1:0];
    e.l = s_tlast;
    e.c = cnt;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic check_out(input int d);
    exp_t e;
    bit   empty;
    empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
    checks++;
    assert (!empty) else begin
      errors++;
      $error("FAIL spurious_out%0d observed=%0h expected=none", d, m_tdata[d]);
    end
    if (!empty) begin
      if (d == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      chk($sformatf("data%0d", d), 64'(m_tdata[d]), 64'(e.d));
      chk($sformatf("last%0d", d), 64'(m_tlast[d]), 64'(e.l));
      if (lat_chk) chk($sformatf("latency%0d", d), 64'(cnt - e.c), 64'd3);
      if (d == 0) last_obs = m_tdata[0];
    end
  endtask

  // One clock: sample at mid-cycle, update the model, then advance past the edge.
  task automatic cycle();
    #4;
    if (coef_we && coef_addr < 6'(NT)) cm[coef_addr] = longint'(coef_wdata);
    acc_seen = 1'b0;
    if (m_tvalid[0]) vcount++;
    for (int d = 0; d < 2; d++) begin
      if (held[d]) begin
        chk($sformatf("stall_valid%0d", d), 64'(m_tvalid[d]), 64'd1);
        chk($sformatf("stall_data%0d", d), 64'(m_tdata[d]), 64'(hd[d]));
        chk($sformatf("stall_last%0d", d), 64'(m_tlast[d]), 64'(hl[d]));
      end
      if (m_tvalid[d] && m_tready) check_out(d);
      if (s_tvalid && s_tready[d]) begin
        model_accept(d);
        if (d == 0) acc_seen = 1'b1;
      end
      held[d] = m_tvalid[d] && !m_tready;
      if (held[d]) begin
        hd[d] = m_tdata[d];
        hl[d] = m_tlast[d];
        chk($sformatf("stall_ready%0d", d), 64'(s_tready[d]), 64'd0);
      end
    end
    @(posedge clk);
    cnt++;
    #1;
    if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic signed [15:0] x, input logic l);
    s_tvalid = 1'b1;
    s_tdata  = x;
    s_tlast  = l;
    for (int n = 0; n < 200; n++) begin
      cycle();
      if (acc_seen) break;
    end
    checks++;
    assert (acc_seen) else begin
      errors++;
      $error("FAIL accept_timeout observed=0 expected=1");
    end
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic drain();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    rand_rdy = 1'b0;
    m_tready = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      cycle();
    end
    chk("drain0", 64'(q0.size()), 64'd0);
    chk("drain1", 64'(q1.size()), 64'd0);
  endtask

  task automatic wr_coef(input logic [5:0] a, input logic signed [15:0] v);
    coef_we    = 1'b1;
    coef_addr  = a;
    coef_wdata = v;
    cycle();
    coef_we = 1'b0;
  endtask

  // Asynchronous reset applied mid-cycle; outputs must drop before any clock edge.
  task automatic do_reset();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    rst_n    = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_valid%0d", d), 64'(m_tvalid[d]), 64'd0);
      chk($sformatf("rst_ready%0d", d), 64'(s_tready[d]), 64'd0);
      chk($sformatf("rst_data%0d", d), 64'(m_tdata[d]), 64'd0);
      chk($sformatf("rst_last%0d", d), 64'(m_tlast[d]), 64'd0);
    end
    model_reset();
    @(posedge clk);
    cnt++;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    s_tdata    = '0;
    s_tvalid   = 1'b0;
    s_tlast    = 1'b0;
    m_tready   = 1'b1;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_wdata = '0;
    last_obs   = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Passthrough with default coefficients, latency and valid-cycle count checked.
    vcount  = 0;
    lat_chk = 1'b1;
    send(16'sd5, 1'b0);
    send(-16'sd3, 1'b0);
    send(16'sh7fff, 1'b0);
    send(16'sh8000, 1'b0);
    idle(6);
    drain();
    lat_chk = 1'b0;
    chk("valid_cycles", 64'(vcount), 64'd4);

    // Impulse response through programmed taps; out-of-range write must be ignored.
    do_reset();
    for (int i = 0; i < NT; i++) wr_coef(6'(i), 16'(i + 1));
    wr_coef(6'd20, 16'sd999);
    send(16'sd1, 1'b0);
    for (int i = 0; i < 20; i++) send(16'sd0, 1'b0);
    drain();

    // Full-scale: every product is +2^30, summed over all taps.
    for (int i = 0; i < NT; i++) wr_coef(6'(i), 16'sh8000);
    for (int i = 0; i < NT; i++) send(16'sh8000, 1'b0);
    drain();
    chk("full_scale", 64'(last_obs), 64'd16106127360);

    // Reset with three samples in flight; nothing stale may emerge afterwards.
    send(16'sd10, 1'b0);
    send(16'sd20, 1'b0);
    send(16'sd30, 1'b0);
    do_reset();
    idle(10);
    send(16'sd7, 1'b0);
    drain();
    chk("post_reset", 64'(last_obs), 64'd7);

    // Ramp under random backpressure with random packet boundaries.
    rand_rdy = 1'b1;
    for (int v = 1; v <= 50; v++) send(16'(v), 1'($urandom_range(0, 7) == 0));
    drain();
    chk("ramp_end", 64'(last_obs), 64'd50);

    // Packet boundary behaviour with all-ones taps.
    do_reset();
    for (int i = 0; i < NT; i++) wr_coef(6'(i), 16'sd1);
    send(16'sd10, 1'b0);
    send(16'sd10, 1'b0);
    send(16'sd10, 1'b1);
    send(16'sd1, 1'b0);
    send(16'sd1, 1'b0);
    drain();
    chk("pkt_b_noclear", 64'(last_obs), 64'd32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_fir_param.md
Name: axis_fir_param

Overview:
Parametrised, fully pipelined direct-form FIR filter with AXI4-Stream slave input and master output, runtime-programmable coefficients, and full backpressure support. It supersedes the fixed 15-tap low-pass filter in the DSP datapath. The block propagates tlast aligned with each sample and can optionally clear filter history at packet boundaries. It sits between the sample source (ADC or stimulus FIFO) and downstream decimation/packetisation logic.

Parameters:
DATA_W, 16, signed input sample width.
COEF_W, 16, signed coefficient width.
NTAPS, 15, number of taps (2..64).
OUT_W, DATA_W+COEF_W+$clog2(NTAPS), full-precision output width (localparam, not overridable).
CLEAR_ON_LAST, 0, 1 = delay-line history is zeroed between packets.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
s_axis_tdata  in  DATA_W  signed input sample
s_axis_tvalid  in  1  input sample valid
s_axis_tlast  in  1  last sample of packet
s_axis_tready  out  1  block can accept a sample
m_axis_tdata  out  OUT_W  signed filtered output
m_axis_tvalid  out  1  output valid
m_axis_tlast  out  1  tlast aligned with output sample
m_axis_tready  in  1  downstream ready
coef_we  in  1  coefficient write strobe
coef_addr  in  6  tap index
coef_wdata  in  COEF_W  signed coefficient value

Behaviour:
- Reset (asynchronous, active-low): delay line = 0, products = 0, v1/v2/v3 = 0, m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tlast = 0, clear-pending flag = 0. Coefficients reset to coef[0] = 1 and all others 0, so the block passes input through unchanged. s_axis_tready = 0 while reset is asserted.
- Pipeline enable: ce = !(v3 && !m_axis_tready). s_axis_tready = ce when not in reset; this path is combinational from m_axis_tready. accept = s_axis_tvalid && s_axis_tready.
- Stage 1 (delay line) updates only on accept: dl[0] <= tdata, dl[i] <= dl[i-1]. v1 <= accept when ce. tlast is carried in t1.
- Stage 2 (on ce): p[i] <= coef[i] * dl[i] as a signed multiply of width DATA_W+COEF_W. v2 <= v1, t2 <= t1.
- Stage 3 (on ce): m_axis_tdata <= sign-extended sum of all p[i] in OUT_W bits. The sum is exact and never overflows; no rounding or saturation is applied. v3 <= v2, m_axis_tlast <= t2.
- Latency: a sample accepted at edge N produces output that is valid after edge N+2 if m_axis_tready stays high. Throughput is 1 sample per clock.
- Bubbles: a cycle with no accept inserts an invalid slot. m_axis_tvalid is low for that slot, and the delay line does not shift.
- Backpressure: while m_axis_tvalid=1 and m_axis_tready=0, the whole pipeline freezes. m_axis_tdata, m_axis_tlast, and m_axis_tvalid stay stable, and s_axis_tready=0. No sample is ever dropped or duplicated.
- Filter startup: history is zero-initialised, so every accepted sample produces exactly one output, including the first NTAPS-1 transient outputs.
- Coefficient writes: a write with coef_we=1 and coef_addr<NTAPS updates coef[coef_addr] at the edge, regardless of ce. Writes with coef_addr>=NTAPS are ignored. A product captured at edge E uses the coefficient values present before edge E.
- CLEAR_ON_LAST=1: accepting a sample with tlast=1 sets clear_pending. The next accept loads dl[0] with the new sample, sets dl[1..NTAPS-1] to 0, and clears clear_pending. The tlast sample's own output still uses full history. With CLEAR_ON_LAST=0, s_axis_tlast only propagates to m_axis_tlast.
- Reset mid-stream: all in-flight samples are discarded and no output is produced for them. After release, the block behaves as out of power-on reset, including coefficients returning to their reset values.

Test Plan:
- Passthrough: after reset, send 5, -3, 32767, -32768 with m_axis_tready=1 -> outputs 5, -3, 32767, -32768 (sign-extended), each 2 edges after accept, with tvalid high for exactly 4 cycles.
- Impulse: write coef[i]=i+1 for i=0..14, send 1 followed by 20 zeros -> outputs 1, 2, ..., 15 then 0s. A write to coef_addr=20 beforehand must leave the outputs unchanged.
- Backpressure: stream a ramp 1..50 with unity coefficients while m_axis_tready toggles at random (about 50%) -> output is exactly 1..50 in order, tdata is held stable while stalled, and s_axis_tready is low whenever the output is stalled and valid.
- Packet clear: with CLEAR_ON_LAST=1 and coef=all 1, send packet A = {10, 10, 10 (tlast)} then B = {1, 1} -> outputs 10, 20, 30(tlast), 1, 2. With CLEAR_ON_LAST=0, the B outputs are 31, 32.
- Full-scale: all coefficients = -32768 and inputs = -32768 for NTAPS samples -> final output = 15*2^30 with no overflow in 36 bits.
- Reset mid-stream: assert reset while 3 samples are in flight -> m_axis_tvalid=0 immediately and no stale outputs appear after release. A subsequent input of 7 outputs 7.
